// File: rtl/vs_arb_mux_nx1_pkg.sv
// Shared types and helpers for the N-to-1 arbitrated stream mux.
package vs_mux_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Select width that never collapses to zero bits (N=1 still gets a 1-bit index).
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vs_rr_arbiter.sv
// Combinational N-way arbiter: round-robin from a pointer or fixed lowest-index
// priority, with an optional lock that restricts the grant to one channel.
module vs_rr_arbiter
    import vs_mux_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int ARB_MODE = 0,
    localparam int SEL_W    = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             lock_en,
    input  logic [SEL_W-1:0] lock_idx,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Pick the winner; loops scan downward so the highest-priority candidate is written last.
    always_comb begin
        int idx;
        idx         = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (lock_en) begin
            // Locked: only the owning channel may win, even if it is idle.
            grant_idx   = lock_idx;
            grant_valid = req[lock_idx];
        end else if (ARB_MODE == int'(ARB_FIXED)) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant_idx   = SEL_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            // Search starts at ptr and wraps; k=0 is the highest priority.
            for (int k = N - 1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % N;
                if (req[idx]) begin
                    grant_idx   = SEL_W'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign grant = grant_valid ? (N'(1) << grant_idx) : '0;

endmodule

// File: rtl/vs_arb_mux_nx1.sv
// N-to-1 valid/ready stream mux: internal arbiter picks a channel, the winner's
// beat lands in a single registered output stage (1-cycle latency, full rate).
module vs_arb_mux_nx1
    import vs_mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int N        = 4,
    parameter  int ARB_MODE = 0,
    parameter  int LOCK_PKT = 0,
    localparam int SEL_W    = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    logic [SEL_W-1:0] ptr;
    logic             lock;
    logic [SEL_W-1:0] lock_idx;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [SEL_W-1:0] ptr_nxt;

    vs_rr_arbiter #(
        .N        (N),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .lock_en     ((LOCK_PKT != 0) && lock),
        .lock_idx    (lock_idx),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Output register can take a new beat when empty or being drained this cycle.
    assign load_en  = !out_valid || out_ready;
    assign xfer     = load_en && grant_valid && !rst;
    assign in_ready = xfer ? grant : '0;
    assign ptr_nxt  = SEL_W'((int'(grant_idx) + 1) % N);

    // One-hot AND-OR select of the winning channel's data and last flag.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_last = in_last[i];
            end
        end
    end

    // Output stage: load on accepted beat, empty when drained with nothing new, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (load_en) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= sel_data;
                out_last <= sel_last;
                out_sel  <= grant_idx;
            end
        end
    end

    // Arbitration state: packet lock and round-robin pointer, advanced only on transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (xfer) begin
            if ((LOCK_PKT != 0) && !sel_last) begin
                // Mid-packet: pin the grant and hold the pointer until the last beat.
                lock     <= 1'b1;
                lock_idx <= grant_idx;
            end else begin
                lock <= 1'b0;
                if (ARB_MODE == int'(ARB_RR)) ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vs_arb_mux_nx1.sv
// Bench for vs_arb_mux_nx1: four instances (RR, fixed, RR+lock, N=1 W=16),
// scoreboard queues for output ordering plus a fixed-priority vector table.
module tb_vs_arb_mux_nx1;

    typedef struct {
        int          sel;
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        int         exp_sel;
    } vec_t;

    logic clk, rst, rst_c;
    int   total, bad;
    beat_t qa[$], qc[$], qd[$];

    // a: RR
    logic [3:0] a_iv, a_il, a_ir; logic [31:0] a_data;
    logic a_ov, a_ol, a_ordy; logic [7:0] a_od; logic [1:0] a_sel;
    // b: fixed priority
    logic [3:0] b_iv, b_il, b_ir; logic [31:0] b_data;
    logic b_ov, b_ol, b_ordy; logic [7:0] b_od; logic [1:0] b_sel;
    // c: RR with packet lock
    logic [3:0] c_iv, c_il, c_ir; logic [31:0] c_data;
    logic c_ov, c_ol, c_ordy; logic [7:0] c_od; logic [1:0] c_sel;
    // d: single channel, 16-bit
    logic d_iv, d_il, d_ir; logic [15:0] d_data;
    logic d_ov, d_ol, d_ordy; logic [15:0] d_od; logic d_sel;

    vs_arb_mux_nx1 #(.WIDTH(8), .N(4), .ARB_MODE(0), .LOCK_PKT(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_data(a_data), .in_last(a_il), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_last(a_ol), .out_sel(a_sel), .out_ready(a_ordy));
    vs_arb_mux_nx1 #(.WIDTH(8), .N(4), .ARB_MODE(1), .LOCK_PKT(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_data(b_data), .in_last(b_il), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_last(b_ol), .out_sel(b_sel), .out_ready(b_ordy));
    vs_arb_mux_nx1 #(.WIDTH(8), .N(4), .ARB_MODE(0), .LOCK_PKT(1)) u_c (
        .clk(clk), .rst(rst_c), .in_valid(c_iv), .in_data(c_data), .in_last(c_il), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_last(c_ol), .out_sel(c_sel), .out_ready(c_ordy));
    vs_arb_mux_nx1 #(.WIDTH(16), .N(1), .ARB_MODE(0), .LOCK_PKT(0)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_iv), .in_data(d_data), .in_last(d_il), .in_ready(d_ir),
        .out_valid(d_ov), .out_data(d_od), .out_last(d_ol), .out_sel(d_sel), .out_ready(d_ordy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic beat_t mk(input int s, input logic [15:0] d, input logic l);
        beat_t b;
        b.sel = s; b.data = d; b.last = l;
        return b;
    endfunction

    // Sample output handshakes on the falling edge, then advance past the next rising edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (a_ov && a_ordy) begin
            if (qa.size() == 0) begin total++; bad++; $display("FAIL a_extra act=%h exp=none", a_od); end
            else begin
                e = qa.pop_front();
                chk("a_sel", 32'(a_sel), 32'(e.sel)); chk("a_data", 32'(a_od), 32'(e.data)); chk("a_last", 32'(a_ol), 32'(e.last));
            end
        end
        if (c_ov && c_ordy) begin
            if (qc.size() == 0) begin total++; bad++; $display("FAIL c_extra act=%h exp=none", c_od); end
            else begin
                e = qc.pop_front();
                chk("c_sel", 32'(c_sel), 32'(e.sel)); chk("c_data", 32'(c_od), 32'(e.data)); chk("c_last", 32'(c_ol), 32'(e.last));
            end
        end
        if (d_ov && d_ordy) begin
            if (qd.size() == 0) begin total++; bad++; $display("FAIL d_extra act=%h exp=none", d_od); end
            else begin
                e = qd.pop_front();
                chk("d_sel", 32'(d_sel), 32'(e.sel)); chk("d_data", 32'(d_od), 32'(e.data)); chk("d_last", 32'(d_ol), 32'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (qa.size() + qc.size() + qd.size()) != 0; i++) tick();
        chk("sb_pending", 32'(qa.size() + qc.size() + qd.size()), 32'd0);
    endtask

    vec_t vt[7];

    initial begin
        total = 0; bad = 0;
        // Fixed-priority vectors: in_valid pattern, expected in_ready, output after the edge.
        vt[0] = '{4'b1010, 4'b0010, 1'b1, 1};
        vt[1] = '{4'b1010, 4'b0010, 1'b1, 1};
        vt[2] = '{4'b1000, 4'b1000, 1'b1, 3};
        vt[3] = '{4'b0000, 4'b0000, 1'b0, 0};
        vt[4] = '{4'b1111, 4'b0001, 1'b1, 0};
        vt[5] = '{4'b1100, 4'b0100, 1'b1, 2};
        vt[6] = '{4'b0000, 4'b0000, 1'b0, 0};

        rst = 1'b1; rst_c = 1'b1;
        a_iv = 4'hF; a_il = '0; a_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; a_ordy = 1'b1;
        b_iv = '0; b_il = '0; b_data = {8'h13, 8'h12, 8'h11, 8'h10}; b_ordy = 1'b1;
        c_iv = 4'hF; c_il = '0; c_data = '0; c_ordy = 1'b1;
        d_iv = 1'b1; d_il = 1'b0; d_data = 16'h0; d_ordy = 1'b1;

        // Reset: ready held low while rst is high, outputs cleared.
        #1;
        chk("rst_a_ready", 32'(a_ir), 32'd0);
        chk("rst_c_ready", 32'(c_ir), 32'd0);
        chk("rst_d_ready", 32'(d_ir), 32'd0);
        tick(); tick();
        chk("rst_a_ov", 32'(a_ov), 32'd0); chk("rst_a_od", 32'(a_od), 32'd0);
        chk("rst_a_sel", 32'(a_sel), 32'd0); chk("rst_a_ol", 32'(a_ol), 32'd0);
        chk("rst_c_ov", 32'(c_ov), 32'd0); chk("rst_d_ov", 32'(d_ov), 32'd0);
        c_iv = '0; d_iv = 1'b0;
        rst = 1'b0; rst_c = 1'b0;

        // Round-robin full-rate sweep 0,1,2,3,0.
        qa.push_back(mk(0, 16'hA0, 0)); qa.push_back(mk(1, 16'hA1, 0)); qa.push_back(mk(2, 16'hA2, 0));
        qa.push_back(mk(3, 16'hA3, 0)); qa.push_back(mk(0, 16'hA0, 0));
        #1;
        chk("rr_first_ready", 32'(a_ir), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_ov_cont", 32'(a_ov), 32'd1);
            if (k < 4) chk("rr_ready", 32'(a_ir), 32'(4'b0001 << ((k + 1) % 4)));
        end
        a_iv = '0;
        tick();
        chk("rr_ov_drop", 32'(a_ov), 32'd0);
        drain();

        // Backpressure on channel 2, then accept in the same cycle out_ready returns.
        a_iv = 4'b0100; a_data[23:16] = 8'h5C;
        qa.push_back(mk(2, 16'h5C, 0));
        #1;
        chk("bp_ready0", 32'(a_ir), 32'b0100);
        tick();
        a_data[23:16] = 8'h5D; a_ordy = 1'b0;
        qa.push_back(mk(2, 16'h5D, 0));
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ov_hold", 32'(a_ov), 32'd1);
            chk("bp_od_hold", 32'(a_od), 32'h5C);
            chk("bp_ready_low", 32'(a_ir), 32'd0);
            tick();
        end
        a_ordy = 1'b1;
        #1;
        chk("bp_ready_resume", 32'(a_ir), 32'b0100);
        tick();
        a_iv = '0;
        tick();
        drain();

        // Fixed priority table.
        for (int r = 0; r < 7; r++) begin
            b_iv = vt[r].vld;
            #1;
            chk("fp_ready", 32'(b_ir), 32'(vt[r].exp_rdy));
            tick();
            chk("fp_ov", 32'(b_ov), 32'(vt[r].exp_ov));
            if (vt[r].exp_ov) begin
                chk("fp_sel", 32'(b_sel), 32'(vt[r].exp_sel));
                chk("fp_data", 32'(b_od), 32'(8'h10 + vt[r].exp_sel));
                chk("fp_last", 32'(b_ol), 32'd0);
            end
        end

        // Packet lock: ch0 3-beat packet with a 2-cycle stall, ch1 waits.
        c_data[15:8] = 8'hD0; c_il[1] = 1'b1;
        c_data[7:0] = 8'hC0; c_il[0] = 1'b0; c_iv = 4'b0011;
        qc.push_back(mk(0, 16'hC0, 0)); qc.push_back(mk(0, 16'hC1, 0));
        qc.push_back(mk(0, 16'hC2, 1)); qc.push_back(mk(1, 16'hD0, 1));
        #1;
        chk("lk_ready_b0", 32'(c_ir), 32'b0001);
        tick();
        c_data[7:0] = 8'hC1;
        #1;
        chk("lk_ready_b1", 32'(c_ir), 32'b0001);
        tick();
        c_iv = 4'b0010;
        #1;
        chk("lk_stall_ready", 32'(c_ir), 32'd0);
        tick();
        chk("lk_bubble", 32'(c_ov), 32'd0);
        chk("lk_stall_ready2", 32'(c_ir), 32'd0);
        tick();
        c_data[7:0] = 8'hC2; c_il[0] = 1'b1; c_iv = 4'b0011;
        #1;
        chk("lk_ready_b2", 32'(c_ir), 32'b0001);
        tick();
        c_iv = 4'b0010;
        #1;
        chk("lk_ready_ch1", 32'(c_ir), 32'b0010);
        tick();
        c_iv = '0;
        tick();
        drain();

        // Reset mid-packet: ch1 holds the lock, reset must release it and zero the pointer.
        c_data[15:8] = 8'hE0; c_il[1] = 1'b0; c_iv = 4'b0010;
        qc.push_back(mk(1, 16'hE0, 0));
        tick();
        rst_c = 1'b1;
        c_data[15:8] = 8'hE1; c_il[1] = 1'b1; c_data[7:0] = 8'hF0; c_il[0] = 1'b1; c_iv = 4'b0011;
        #1;
        chk("mr_ready_rst", 32'(c_ir), 32'd0);
        tick();
        chk("mr_ov_rst", 32'(c_ov), 32'd0);
        chk("mr_sel_rst", 32'(c_sel), 32'd0);
        rst_c = 1'b0;
        qc.push_back(mk(0, 16'hF0, 1)); qc.push_back(mk(1, 16'hE1, 1));
        #1;
        chk("mr_ch0_first", 32'(c_ir), 32'b0001);
        tick();
        c_iv = 4'b0010;
        tick();
        c_iv = '0;
        tick();
        drain();

        // N=1 pass-through with out_ready 1,0,1.
        d_iv = 1'b1; d_data = 16'h1234; d_il = 1'b0; d_ordy = 1'b1;
        qd.push_back(mk(0, 16'h1234, 0)); qd.push_back(mk(0, 16'hBEEF, 1));
        #1;
        chk("n1_ready0", 32'(d_ir), 32'd1);
        tick();
        d_data = 16'hBEEF; d_il = 1'b1; d_ordy = 1'b0;
        #1;
        chk("n1_stall_ready", 32'(d_ir), 32'd0);
        chk("n1_od0", 32'(d_od), 32'h1234);
        tick();
        chk("n1_hold_ov", 32'(d_ov), 32'd1);
        chk("n1_hold_od", 32'(d_od), 32'h1234);
        d_ordy = 1'b1;
        #1;
        chk("n1_ready1", 32'(d_ir), 32'd1);
        tick();
        d_iv = 1'b0;
        tick();
        drain();
        chk("n1_ov_end", 32'(d_ov), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vs_arb_mux_nx1.md
Name: vs_arb_mux_nx1

Overview:
Parametrised N-to-1 streaming multiplexer. It arbitrates among N valid/ready input channels and forwards the winner through one registered output stage.
- Replaces fixed 2/3/4-input select-driven muxes wherever sources are independent and back-pressured.
- Selection comes from an internal arbiter (round-robin or fixed priority), not an external select.
- Optional packet lock holds the grant until a channel's last beat.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels (1..32).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- LOCK_PKT, 0, 1 = hold grant on a channel until a beat with in_last=1 is accepted.
- SEL_W, derived as max(1, clog2(N)), width of out_sel (localparam, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  N  per-channel valid.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  in  N  per-channel end-of-packet marker (ignored when LOCK_PKT=0, but still forwarded).
- in_ready  out  N  per-channel ready; at most one bit high per cycle.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered data.
- out_last  out  1  registered last flag.
- out_sel  out  SEL_W  index of the channel that sourced the current beat.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - RR pointer=0, so channel 0 has highest priority on the next arbitration.
  - Lock cleared.
  - in_ready forced to all-zero combinationally while rst=1.
- Load enable: `load_en = !out_valid || out_ready` (single-entry register; no bubble under continuous flow).
- Arbitration (combinational, evaluated every cycle):
  - Requests are in_valid.
  - Round-robin: search starts at the pointer and wraps N-1 → 0.
  - Fixed priority: lowest index with in_valid=1 wins.
- in_ready[g] = load_en && grant_valid for winner g; all other bits 0. in_ready never depends on in_valid of another channel beyond arbitration.
- Transfer when in_valid[g] && in_ready[g]. On the next edge:
  - out_data, out_last, out_sel are loaded from channel g.
  - out_valid=1.
  - Latency is 1 cycle input→output; throughput is 1 beat/cycle.
- If load_en=1 and no request: out_valid←0 on that edge (output consumed, nothing new).
- If out_valid=1 && out_ready=0: all out_* hold, in_ready=0.
- RR pointer update, only on a transfer: pointer←(g+1) mod N. Fixed-priority mode leaves the pointer untouched.
- LOCK_PKT=1:
  - A transfer with in_last=0 sets lock and records g.
  - While locked, only the locked channel may be granted; the pointer does not advance.
  - A transfer with in_last=1 from the locked channel clears lock and advances the pointer.
  - If the locked channel drops in_valid mid-packet, no other channel is granted and output bubbles are allowed.
- N=1: arbiter degenerates to pass-through with the register stage; out_sel=0 always.
- Reset mid-packet: lock and pointer cleared; the partially forwarded packet is abandoned without recovery.
- Inputs must obey AXI-stream-style rules: in_valid/in_data stable until accepted. The block does not check this.

Decomposition:
- Package vs_mux_pkg:
  - enum arb_mode_e {ARB_RR, ARB_FIXED}.
  - Function clog2_min1(n) for SEL_W.
- Sub-module vs_rr_arbiter #(N, ARB_MODE):
  - Inputs: req[N], pointer, lock_en, lock_idx.
  - Outputs: grant one-hot, grant_idx, grant_valid.
  - Purely combinational.
- Pointer and lock registers live in vs_arb_mux_nx1.

Test Plan:
1. Reset, then N=4, RR. All in_valid=1, in_data[i]=8'hA0+i, out_ready=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1 from cycle 2, out_data A0,A1,A2,A3,A0.
2. Backpressure. Channel 2 valid with 8'h5C, out_ready=0 for 3 cycles → out_valid=1, out_data=5C held, in_ready=0 for those cycles. out_ready=1 → next beat accepted the same cycle.
3. Fixed priority (ARB_MODE=1). Channels 1 and 3 continuously valid → only channel 1 granted. Deassert ch1 → ch3 granted next cycle.
4. LOCK_PKT=1. ch0 sends a 3-beat packet (last on beat 3) while ch1 is valid throughout → out_sel=0,0,0 then 1. Stall ch0 valid for 2 cycles mid-packet → out_valid drops, ch1 not granted.
5. Reset mid-packet. rst=1 for 1 cycle during test 4 beat 2 → out_valid=0, in_ready=0 during rst. Afterwards ch0 and ch1 both valid → ch0 granted first (pointer=0, lock cleared).
6. N=1, WIDTH=16. Stream 16'h1234, 16'hBEEF with out_ready toggling 1,0,1 → outputs appear in order, one cycle late, each held while out_ready=0, out_sel=0.
